// File: rtl/nios_system_mem_copy_master_if.sv
// nios_system_mem_copy_master_if: command/status and Avalon-MM master signals of the block copier.
interface nios_system_mem_copy_master_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 12
);
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len_words;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [LEN_W-1:0]  words_done;
    logic [15:0]       csum;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic              avm_waitrequest;
    modport master (
        input  start, src_addr, dst_addr, len_words, abort,
               avm_readdata, avm_readdatavalid, avm_waitrequest,
        output busy, done, aborted, words_done, csum,
               avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
    );
    modport slave (
        output start, src_addr, dst_addr, len_words, abort,
               avm_readdata, avm_readdatavalid, avm_waitrequest,
        input  busy, done, aborted, words_done, csum,
               avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
    );
endinterface

// File: rtl/nios_system_mem_copy_master.sv
// nios_system_mem_copy_master: Avalon-MM word copier, one transaction outstanding, all outputs registered.
// Define MEM_COPY_CSUM_EN to accumulate a ones-complement sum of every word read into csum.
module nios_system_mem_copy_master #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 12
) (
    input logic                           clk,
    input logic                           reset_n,
    nios_system_mem_copy_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d, wdone_q, wdone_d;
    logic [31:0]       buf_q, buf_d;
    logic              abt_q, abt_d, abt_now;
    logic              aborted_q, aborted_d, busy_q, busy_d, done_q, done_d;
    logic              read_q, read_d, write_q, write_d;
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        wdone_d   = wdone_q;
        buf_d     = buf_q;
        aborted_d = aborted_q;
        abt_now   = abt_q | bus.abort;
        abt_d     = (state_q != IDLE) ? abt_now : abt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                src_d     = bus.src_addr & ~ADDR_W'(3);
                dst_d     = bus.dst_addr & ~ADDR_W'(3);
                rem_d     = bus.len_words;
                wdone_d   = '0;
                aborted_d = 1'b0;
                abt_d     = 1'b0;
                state_d   = (bus.len_words == '0) ? DONE : RD;
            end
            RD: if (!bus.avm_waitrequest) state_d = RD_WAIT;
            RD_WAIT: if (bus.avm_readdatavalid) begin
                buf_d   = bus.avm_readdata;
                state_d = WR;
            end
            WR: if (!bus.avm_waitrequest) begin
                src_d     = src_q + ADDR_W'(4);
                dst_d     = dst_q + ADDR_W'(4);
                wdone_d   = wdone_q + LEN_W'(1);
                rem_d     = rem_q - LEN_W'(1);
                state_d   = (rem_d == '0 || abt_now) ? DONE : RD;
                aborted_d = (rem_d != '0) && abt_now;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Bus outputs are derived from the next state so they appear registered with it.
        busy_d  = state_d != IDLE;
        done_d  = state_d == DONE;
        read_d  = state_d == RD;
        write_d = state_d == WR;
        addr_d  = read_d ? src_d : write_d ? dst_d : addr_q;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            wdone_q   <= '0;
            buf_q     <= '0;
            abt_q     <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wdone_q   <= wdone_d;
            buf_q     <= buf_d;
            abt_q     <= abt_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            read_q    <= read_d;
            write_q   <= write_d;
        end
`ifdef MEM_COPY_CSUM_EN
    logic [15:0] csum_q, csum_d;
    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction
    always_comb
        csum_d = (state_q == IDLE && bus.start) ? 16'h0000 :
                 (state_q == RD_WAIT && bus.avm_readdatavalid) ?
                 oc_add(oc_add(csum_q, bus.avm_readdata[31:16]), bus.avm_readdata[15:0]) : csum_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) csum_q <= '0;
        else csum_q <= csum_d;
    assign bus.csum = csum_q;
`else
    assign bus.csum = 16'h0000;
`endif
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.aborted        = aborted_q;
    assign bus.words_done     = wdone_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_read       = read_q;
    assign bus.avm_write      = write_q;
    assign bus.avm_byteenable = 4'hF;
    assign bus.avm_writedata  = buf_q;
endmodule

// File: tb/tb_nios_system_mem_copy_master.sv
// tb_nios_system_mem_copy_master: directed scenarios against an Avalon memory model with optional stalls.
`timescale 1ns/1ps
module tb_nios_system_mem_copy_master;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 12;
    localparam logic [31:0] PAT [4] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    nios_system_mem_copy_master_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();
    nios_system_mem_copy_master #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] src_mem [logic [29:0]];
    logic stall_en = 1'b0;
    int rd_n = 0, wr_n = 0, viol = 0, done_n = 0, act_n = 0;
    logic [31:0] ra [512];
    logic [31:0] wa [512];
    logic [31:0] wd [512];
    logic pend = 1'b0;
    int pend_cnt = 0;
    logic [31:0] pend_data = '0;
    logic hold = 1'b0;
    logic h_rd = 1'b0, h_wr = 1'b0;
    logic [31:0] h_addr = '0, h_data = '0;

    always @(negedge clk) bus.avm_waitrequest <= stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;

    // Memory slave plus bus monitor: records every accepted access and any instability during stalls.
    always @(posedge clk) begin
        int lat;
        logic [31:0] rdat;
        bus.avm_readdatavalid <= 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                bus.avm_readdatavalid <= 1'b1;
                bus.avm_readdata <= pend_data;
                pend <= 1'b0;
            end else pend_cnt <= pend_cnt - 1;
        end
        viol <= viol + int'(bus.avm_read && bus.avm_write) +
                int'(hold && (bus.avm_address !== h_addr || bus.avm_read !== h_rd ||
                              bus.avm_write !== h_wr || (h_wr && bus.avm_writedata !== h_data)));
        hold   <= (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
        h_addr <= bus.avm_address;
        h_rd   <= bus.avm_read;
        h_wr   <= bus.avm_write;
        h_data <= bus.avm_writedata;
        if (bus.avm_read || bus.avm_write) act_n <= act_n + 1;
        if (bus.done) done_n <= done_n + 1;
        if (bus.avm_read && !bus.avm_waitrequest) begin
            ra[rd_n] <= bus.avm_address;
            rd_n <= rd_n + 1;
            rdat = src_mem.exists(bus.avm_address[31:2]) ? src_mem[bus.avm_address[31:2]] : 32'hDEADBEEF;
            lat = stall_en ? 1 + int'($urandom_range(0, 2)) : 1;
            if (lat == 1) begin
                bus.avm_readdatavalid <= 1'b1;
                bus.avm_readdata <= rdat;
            end else begin
                pend <= 1'b1;
                pend_cnt <= lat - 2;
                pend_data <= rdat;
            end
        end
        if (bus.avm_write && !bus.avm_waitrequest) begin
            wa[wr_n] <= bus.avm_address;
            wd[wr_n] <= bus.avm_writedata;
            wr_n <= wr_n + 1;
        end
    end

    // Issues one command, optionally pulses abort / a stray start at given cycles, returns done cycle (0 = timeout).
    task automatic copy(input logic [31:0] s, input logic [31:0] d, input logic [11:0] n,
                        input int ab_c, input int st_c, output int dc);
        @(negedge clk);
        bus.src_addr = s;
        bus.dst_addr = d;
        bus.len_words = n;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        dc = 0;
        for (int c = 1; c <= 2000 && dc == 0; c++) begin
            @(negedge clk);
            bus.abort = (c == ab_c);
            bus.start = (c == st_c);
            if (c == st_c) begin
                bus.src_addr = 32'h900;
                bus.len_words = 12'd5;
            end
            if (bus.done) dc = c;
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.len_words = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got %b want 0", bus.aborted); end
        checks++; if (bus.words_done !== 12'd0) begin errors++; $display("FAIL reset_words_done got %0d want 0", bus.words_done); end
        checks++; if (bus.csum !== 16'h0) begin errors++; $display("FAIL reset_csum got %h want 0000", bus.csum); end
        checks++; if (bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0) begin errors++; $display("FAIL reset_rw got %b%b want 00", bus.avm_read, bus.avm_write); end
        checks++; if (bus.avm_address !== 32'h0) begin errors++; $display("FAIL reset_address got %h want 0", bus.avm_address); end
        checks++; if (bus.avm_writedata !== 32'h0) begin errors++; $display("FAIL reset_writedata got %h want 0", bus.avm_writedata); end
        checks++; if (bus.avm_byteenable !== 4'hF) begin errors++; $display("FAIL byteenable got %h want f", bus.avm_byteenable); end
        reset_n = 1'b1;
    endtask

    task automatic test_basic_copy;
        int dc, r0, w0;
        for (int i = 0; i < 4; i++) src_mem[30'h40 + 30'(i)] = PAT[i];
        r0 = rd_n; w0 = wr_n;
        copy(32'h100, 32'h200, 12'd4, 0, 0, dc);
        checks++; if (dc != 13) begin errors++; $display("FAIL basic_done_cycle got %0d want 13", dc); end
        checks++; if (bus.words_done !== 12'd4) begin errors++; $display("FAIL basic_words_done got %0d want 4", bus.words_done); end
        checks++; if (bus.aborted !== 1'b0) begin errors++; $display("FAIL basic_aborted got %b want 0", bus.aborted); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL basic_after_done got done=%b busy=%b want 0 0", bus.done, bus.busy); end
        checks++; if (rd_n - r0 != 4 || wr_n - w0 != 4) begin errors++; $display("FAIL basic_counts got rd=%0d wr=%0d want 4 4", rd_n - r0, wr_n - w0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ra[r0+i] !== 32'h100 + 32'(4*i) || wa[w0+i] !== 32'h200 + 32'(4*i) || wd[w0+i] !== PAT[i]) begin
                errors++;
                $display("FAIL basic_word%0d got rd@%h wr@%h data %h want rd@%h wr@%h data %h", i, ra[r0+i], wa[w0+i], wd[w0+i],
                         32'h100 + 32'(4*i), 32'h200 + 32'(4*i), PAT[i]);
            end
        end
    endtask

    task automatic test_stalls;
        int dc, r0, w0, v0;
        r0 = rd_n; w0 = wr_n; v0 = viol;
        stall_en = 1'b1;
        copy(32'h100, 32'h280, 12'd4, 0, 0, dc);
        stall_en = 1'b0;
        checks++; if (dc == 0) begin errors++; $display("FAIL stall_timeout got no done want done"); end
        repeat (2) @(negedge clk);
        checks++; if (rd_n - r0 != 4 || wr_n - w0 != 4) begin errors++; $display("FAIL stall_counts got rd=%0d wr=%0d want 4 4", rd_n - r0, wr_n - w0); end
        checks++; if (viol != v0) begin errors++; $display("FAIL stall_stability got %0d violations want 0", viol - v0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa[w0+i] !== 32'h280 + 32'(4*i) || wd[w0+i] !== PAT[i]) begin
                errors++;
                $display("FAIL stall_word%0d got %h@%h want %h@%h", i, wd[w0+i], wa[w0+i], PAT[i], 32'h280 + 32'(4*i));
            end
        end
    endtask

    task automatic test_len_zero;
        int dc, a0;
        a0 = act_n;
        copy(32'h100, 32'h200, 12'd0, 0, 0, dc);
        checks++; if (dc != 1) begin errors++; $display("FAIL len0_done_cycle got %0d want 1", dc); end
        checks++; if (bus.words_done !== 12'd0) begin errors++; $display("FAIL len0_words_done got %0d want 0", bus.words_done); end
        repeat (4) @(negedge clk);
        checks++; if (act_n != a0) begin errors++; $display("FAIL len0_bus_activity got %0d cycles want 0", act_n - a0); end
    endtask

    task automatic test_abort;
        int dc, r0, w0;
        for (int i = 0; i < 8; i++) src_mem[30'hC0 + 30'(i)] = 32'h30000000 + 32'(i);
        r0 = rd_n; w0 = wr_n;
        copy(32'h300, 32'h400, 12'd8, 8, 0, dc);
        checks++; if (dc != 10) begin errors++; $display("FAIL abort_done_cycle got %0d want 10", dc); end
        checks++; if (bus.aborted !== 1'b1) begin errors++; $display("FAIL abort_flag got %b want 1", bus.aborted); end
        checks++; if (bus.words_done !== 12'd3) begin errors++; $display("FAIL abort_words_done got %0d want 3", bus.words_done); end
        repeat (6) @(negedge clk);
        checks++; if (rd_n - r0 != 3 || wr_n - w0 != 3) begin errors++; $display("FAIL abort_counts got rd=%0d wr=%0d want 3 3", rd_n - r0, wr_n - w0); end
        checks++; if (wa[w0+2] !== 32'h408 || wd[w0+2] !== 32'h30000002) begin errors++; $display("FAIL abort_third_write got %h@%h want 30000002@00000408", wd[w0+2], wa[w0+2]); end
        checks++; if (bus.aborted !== 1'b1) begin errors++; $display("FAIL abort_flag_held got %b want 1", bus.aborted); end
    endtask

    task automatic test_wrap_and_busy_start;
        int dc, r0, w0, d0;
        src_mem[30'h3FFFFFFF] = 32'hCAFE0001;
        src_mem[30'h0] = 32'hCAFE0002;
        r0 = rd_n; w0 = wr_n; d0 = done_n;
        copy(32'hFFFFFFFC, 32'h500, 12'd2, 0, 3, dc);
        checks++; if (dc != 7) begin errors++; $display("FAIL wrap_done_cycle got %0d want 7", dc); end
        checks++; if (bus.aborted !== 1'b0) begin errors++; $display("FAIL wrap_aborted got %b want 0", bus.aborted); end
        repeat (12) @(negedge clk);
        checks++; if (ra[r0] !== 32'hFFFFFFFC || ra[r0+1] !== 32'h0) begin errors++; $display("FAIL wrap_read_addr got %h %h want fffffffc 00000000", ra[r0], ra[r0+1]); end
        checks++; if (wd[w0] !== 32'hCAFE0001 || wd[w0+1] !== 32'hCAFE0002) begin errors++; $display("FAIL wrap_data got %h %h want cafe0001 cafe0002", wd[w0], wd[w0+1]); end
        checks++; if (rd_n - r0 != 2 || wr_n - w0 != 2 || done_n - d0 != 1) begin errors++; $display("FAIL busy_start_ignored got rd=%0d wr=%0d done=%0d want 2 2 1", rd_n - r0, wr_n - w0, done_n - d0); end
        checks++; if (bus.words_done !== 12'd2 || bus.busy !== 1'b0) begin errors++; $display("FAIL wrap_status got words=%0d busy=%b want 2 0", bus.words_done, bus.busy); end
    endtask

    task automatic test_csum_and_alignment;
        int dc, r0, w0;
        logic [15:0] exp_csum;
`ifdef MEM_COPY_CSUM_EN
        exp_csum = 16'h0003;
`else
        exp_csum = 16'h0000;
`endif
        src_mem[30'h180] = 32'h00010002;
        src_mem[30'h181] = 32'hFFFF0000;
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        r0 = rd_n; w0 = wr_n;
        copy(32'h601, 32'h703, 12'd2, 0, 0, dc);
        checks++; if (dc != 7) begin errors++; $display("FAIL csum_done_cycle got %0d want 7", dc); end
        checks++; if (bus.csum !== exp_csum) begin errors++; $display("FAIL csum_value got %h want %h", bus.csum, exp_csum); end
        checks++; if (bus.aborted !== 1'b0) begin errors++; $display("FAIL idle_abort_ignored got %b want 0", bus.aborted); end
        @(negedge clk);
        checks++; if (ra[r0] !== 32'h600 || wa[w0] !== 32'h700 || wa[w0+1] !== 32'h704) begin errors++; $display("FAIL align_addr got rd@%h wr@%h,%h want 600 700,704", ra[r0], wa[w0], wa[w0+1]); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        bus.src_addr = 32'h300;
        bus.dst_addr = 32'h800;
        bus.len_words = 12'd8;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (bus.avm_write !== 1'b1) begin errors++; $display("FAIL areset_pre_write got %b want 1", bus.avm_write); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.avm_write !== 1'b0 || bus.avm_read !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL areset_immediate got rd=%b wr=%b busy=%b want 0 0 0", bus.avm_read, bus.avm_write, bus.busy); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.avm_read !== 1'b0) begin errors++; $display("FAIL areset_idle got busy=%b rd=%b want 0 0", bus.busy, bus.avm_read); end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_stalls();
        test_len_zero();
        test_abort();
        test_wrap_and_busy_start();
        test_csum_and_alignment();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
